hdbn_encoder: RTL and testbench
===============================

Name: hdbn_encoder

Overview:
Parametrised HDBn line encoder, the successor to the single-width V-marking stage. Detects runs of ZERO_RUN zeros and substitutes 00..0V or B0..0V according to the running mark parity. Also performs AMI polarity alternation and drives dual-rail P/N outputs to the line driver. Sits between the framer's serial bit stream and the LIU/transformer interface. A selectable plain-AMI mode bypasses substitution.

Parameters:
ZERO_RUN, 4, zero-run length triggering substitution (4 = HDB3); legal range 2..8, elaboration error otherwise
CNT_W, $clog2(ZERO_RUN+1), derived width of the zero-run and position counters; not to be overridden

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
data_in  input  1  NRZ data bit, sampled when data_valid=1
data_valid  input  1  bit strobe; one input bit per high cycle, any duty cycle
mode_ami  input  1  1 = plain AMI (no substitution), 0 = HDBn; sampled with each strobe
sym_out  output  2  symbol class of the current output bit: 00 zero, 01 one, 10 B, 11 V
pos_out  output  1  positive-rail pulse for the current output bit
neg_out  output  1  negative-rail pulse for the current output bit
out_valid  output  1  one-cycle pulse, the cycle after each accepted strobe

Behaviour:
- Interface: Reset rst_n, asynchronous, active-low; clock clk. All state is cleared on reset, and all outputs are registered.
- Reset values:
  - sym_out=00, pos_out=0, neg_out=0, out_valid=0.
  - Delay line filled with SYM_ZERO.
  - Zero counter = 0.
  - Mark parity = even.
  - Last pulse polarity = negative, so the first mark after reset is positive.
- Stall: when data_valid=0, no state advances and pos/neg/sym hold their values. out_valid is 0.
- Pipeline: a ZERO_RUN-entry symbol delay line followed by a polarity register.
  - The bit accepted on strobe k appears on sym/pos/neg after the clock edge of strobe k+ZERO_RUN.
  - Each output update is accompanied by out_valid=1 in the following cycle.
  - The first ZERO_RUN outputs after reset are reset-fill zeros.
- Input classification, per strobe:
  - data_in=1: push SYM_ONE, zero counter := 0, toggle mark parity.
  - data_in=0 with counter < ZERO_RUN-1: push SYM_ZERO, counter += 1.
  - data_in=0 with counter == ZERO_RUN-1 (run complete), in the same strobe:
    - Push SYM_V.
    - If parity is even, rewrite the oldest-entered zero of this run (delay-line slot ZERO_RUN-1 after the shift) to SYM_B.
    - If parity is odd, leave it as a zero.
    - Counter := 0; parity := even (B counts as a mark and V resets the count).
  - Reset-fill zeros never count toward a run.
- AMI mode (mode_ami=1): substitution is disabled, the counter is forced to 0, and parity is unused. Switching mode mid-run discards the partial run; the next run starts counting from the following strobe.
- Polarity stage, at the output end of the delay line:
  - SYM_ONE and SYM_B: emit the opposite of the last pulse polarity, then update the last polarity.
  - SYM_V: emit the same polarity as the last pulse, then update the last polarity (no change).
  - SYM_ZERO: pos=neg=0.
  - pos_out and neg_out are never both 1.
- Back-to-back runs: N consecutive runs of ZERO_RUN zeros each produce a substitution; the second and later runs always see even parity and therefore use B0..0V.
- Reset mid-stream: the pipeline contents are lost with no flush; encoding restarts from the reset state.

Decomposition:
- Shared package hdb_pkg holds:
  - Symbol localparams: SYM_ZERO=2'b00, SYM_ONE=2'b01, SYM_B=2'b10, SYM_V=2'b11.
  - The legal ZERO_RUN bounds.
- One sub-module: hdb_polarity. It takes the symbol class plus strobe and returns pos/neg and holds the last-polarity state. It is reusable by the AMI-only and B8ZS variants.

Test Plan:
- Reset, then feed 0000 (ZERO_RUN=4, HDB3) -> after 4 fill strobes, sym B,0,0,V and pos=1,0,0,1; neg stays 0.
- Feed 1,0000 from reset -> sym 1,0,0,0,V; pos 1,0,0,0,1 (odd parity, V repeats +).
- Feed 1,1,0000,0000 -> rails +,-,+B,0,0,+V,-B,0,0,-V. Check the alternating V polarity and that neither rail is ever both high.
- mode_ami=1, feed 1,0,0,0,0,0,1 -> +,0,0,0,0,0,-, with no V/B symbols. Toggle to mode 0 mid-run -> the partial run is discarded.
- ZERO_RUN=3, feed 1,000 -> sym 1,0,0,V; rails +,0,0,+. Insert random data_valid gaps -> outputs hold and the result is identical to the gapless run.
- Assert rst_n mid-substitution -> outputs 0 immediately; the next 0000 encodes as +B,0,0,+V.

Source files
------------

// File: rtl/hdb_pkg.sv
// hdb_pkg: symbol codes and legal zero-run bounds shared by the HDBn encoder family
package hdb_pkg;
    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_B    = 2'b10;
    localparam logic [1:0] SYM_V    = 2'b11;
    localparam int ZERO_RUN_MIN = 2;
    localparam int ZERO_RUN_MAX = 8;
endpackage

// File: rtl/hdbn_encoder_if.sv
// hdbn_encoder_if: bit-stream input and dual-rail symbol output of the HDBn encoder.
// Ports: data_in/data_valid/mode_ami (framer -> encoder); sym_out/pos_out/neg_out/out_valid (encoder -> LIU).
interface hdbn_encoder_if;
    logic       data_in;
    logic       data_valid;
    logic       mode_ami;
    logic [1:0] sym_out;
    logic       pos_out;
    logic       neg_out;
    logic       out_valid;
    modport master (
        output data_in, data_valid, mode_ami,
        input  sym_out, pos_out, neg_out, out_valid
    );
    modport slave (
        input  data_in, data_valid, mode_ami,
        output sym_out, pos_out, neg_out, out_valid
    );
endinterface

// File: rtl/hdb_polarity.sv
// hdb_polarity: AMI polarity stage turning symbol classes into registered P/N rail pulses.
// Ports: clk, rst_n (async, active-low); sym_in symbol class, strobe advance enable;
//        pos_out/neg_out registered rail pulses, held while strobe is low.
module hdb_polarity
    import hdb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sym_in,
    input  logic       strobe,
    output logic       pos_out,
    output logic       neg_out
);
    logic last_pos_q, last_pos_d;
    logic pos_q, pos_d;
    logic neg_q, neg_d;
    logic mark, pulse, pol;

    // Marks (ONE, B) alternate; V repeats the previous polarity to signal a violation.
    always_comb begin
        mark       = (sym_in == SYM_ONE) || (sym_in == SYM_B);
        pulse      = mark || (sym_in == SYM_V);
        pol        = mark ? !last_pos_q : last_pos_q;
        last_pos_d = (strobe && pulse) ? pol : last_pos_q;
        pos_d      = strobe ? (pulse && pol) : pos_q;
        neg_d      = strobe ? (pulse && !pol) : neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pos_q <= 1'b0;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            last_pos_q <= last_pos_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
        end
    end

    assign pos_out = pos_q;
    assign neg_out = neg_q;
endmodule

// File: rtl/hdbn_encoder.sv
// hdbn_encoder: HDBn line encoder with zero-run substitution, AMI polarity and dual-rail output.
// Ports: clk, rst_n (async, active-low); bus (hdbn_encoder_if.slave) carrying the NRZ input strobe,
//        mode select and the registered sym/pos/neg/out_valid outputs.
module hdbn_encoder
    import hdb_pkg::*;
#(
    parameter int ZERO_RUN = 4,
    parameter int CNT_W    = $clog2(ZERO_RUN + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    hdbn_encoder_if.slave bus
);
    if (ZERO_RUN < ZERO_RUN_MIN || ZERO_RUN > ZERO_RUN_MAX) begin : g_bad_zero_run
        $error("hdbn_encoder: ZERO_RUN must be within 2..8");
    end

    logic [1:0]       dl_q [ZERO_RUN];
    logic [1:0]       dl_d [ZERO_RUN];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             odd_q, odd_d;
    logic [1:0]       sym_q, sym_d;
    logic             ov_q, ov_d;
    logic             run_done;
    logic [1:0]       push;

    // Slot 0 is the newest entry; the symbol leaving slot ZERO_RUN-1 feeds the polarity stage.
    // On a completed run the first zero of that run sits in slot ZERO_RUN-1 after the shift,
    // so it can still be rewritten to B before it leaves the delay line.
    always_comb begin
        run_done = !bus.mode_ami && !bus.data_in && (cnt_q == CNT_W'(ZERO_RUN - 1));
        push     = bus.data_in ? SYM_ONE : (run_done ? SYM_V : SYM_ZERO);
        dl_d     = dl_q;
        cnt_d    = cnt_q;
        odd_d    = odd_q;
        sym_d    = sym_q;
        ov_d     = bus.data_valid;
        if (bus.data_valid) begin
            dl_d[0] = push;
            for (int i = 1; i < ZERO_RUN; i++) dl_d[i] = dl_q[i-1];
            if (run_done && !odd_q) dl_d[ZERO_RUN-1] = SYM_B;
            cnt_d = (bus.mode_ami || bus.data_in || run_done) ? '0 : cnt_q + 1'b1;
            // AMI mode leaves parity untouched; after a substitution B and V leave it even.
            odd_d = bus.mode_ami ? odd_q : (bus.data_in ? !odd_q : (run_done ? 1'b0 : odd_q));
            sym_d = dl_q[ZERO_RUN-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ZERO_RUN; i++) dl_q[i] <= SYM_ZERO;
            cnt_q <= '0;
            odd_q <= 1'b0;
            sym_q <= SYM_ZERO;
            ov_q  <= 1'b0;
        end else begin
            dl_q  <= dl_d;
            cnt_q <= cnt_d;
            odd_q <= odd_d;
            sym_q <= sym_d;
            ov_q  <= ov_d;
        end
    end

    hdb_polarity u_polarity (
        .clk     (clk),
        .rst_n   (rst_n),
        .sym_in  (dl_q[ZERO_RUN-1]),
        .strobe  (bus.data_valid),
        .pos_out (bus.pos_out),
        .neg_out (bus.neg_out)
    );

    assign bus.sym_out   = sym_q;
    assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_hdbn_encoder.sv
// tb_hdbn_encoder: directed-vector bench for hdbn_encoder in HDB3 and ZERO_RUN=3 configurations
module tb_hdbn_encoder;
    logic clk = 1'b0;
    logic rst_n;
    int   asrt_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk = ~clk;

    hdbn_encoder_if b4 ();
    hdbn_encoder_if b3 ();

    hdbn_encoder #(.ZERO_RUN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    hdbn_encoder #(.ZERO_RUN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    task automatic do_reset();
        rst_n = 1'b0;
        b4.data_valid = 1'b0;
        b3.data_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send4(input logic d, input logic m, output logic [1:0] s, output int r, output logic v);
        @(negedge clk);
        b4.data_in = d;
        b4.mode_ami = m;
        b4.data_valid = 1'b1;
        @(posedge clk);
        #1;
        s = b4.sym_out;
        r = b4.pos_out ? (b4.neg_out ? 2 : 1) : (b4.neg_out ? -1 : 0);
        v = b4.out_valid;
        b4.data_valid = 1'b0;
    endtask

    task automatic send3(input logic d, output logic [1:0] s, output int r, output logic v);
        @(negedge clk);
        b3.data_in = d;
        b3.mode_ami = 1'b0;
        b3.data_valid = 1'b1;
        @(posedge clk);
        #1;
        s = b3.sym_out;
        r = b3.pos_out ? (b3.neg_out ? 2 : 1) : (b3.neg_out ? -1 : 0);
        v = b3.out_valid;
        b3.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b4.data_valid = 1'b0;
        b3.data_valid = 1'b0;
        #1;
        asrt_cnt++;
        if ({b4.sym_out, b4.pos_out, b4.neg_out, b4.out_valid} !== 5'b0) begin
            fail_cnt++;
            $display("FAIL reset_z4: sym/pos/neg/ov=%b, expected 00000", {b4.sym_out, b4.pos_out, b4.neg_out, b4.out_valid});
        end
        asrt_cnt++;
        if ({b3.sym_out, b3.pos_out, b3.neg_out, b3.out_valid} !== 5'b0) begin
            fail_cnt++;
            $display("FAIL reset_z3: sym/pos/neg/ov=%b, expected 00000", {b3.sym_out, b3.pos_out, b3.neg_out, b3.out_valid});
        end
        do_reset();
    endtask

    task automatic test_hdb3_even();
        logic       din [8] = '{0,0,0,0,1,1,1,1};
        int         es  [8] = '{0,0,0,0,2,0,0,3};
        int         er  [8] = '{0,0,0,0,1,0,0,1};
        logic [1:0] s;
        int         r;
        logic       v;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send4(din[i], 1'b0, s, r, v);
            asrt_cnt++;
            if (s !== 2'(es[i]) || r != er[i] || v !== 1'b1) begin
                fail_cnt++;
                $display("FAIL hdb3_even[%0d]: sym=%0d rail=%0d ov=%b, expected sym=%0d rail=%0d ov=1", i, s, r, v, es[i], er[i]);
            end
        end
    endtask

    task automatic test_hdb3_odd();
        logic       din [9] = '{1,0,0,0,0,1,1,1,1};
        int         es  [9] = '{0,0,0,0,1,0,0,0,3};
        int         er  [9] = '{0,0,0,0,1,0,0,0,1};
        logic [1:0] s;
        int         r;
        logic       v;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send4(din[i], 1'b0, s, r, v);
            asrt_cnt++;
            if (s !== 2'(es[i]) || r != er[i] || v !== 1'b1) begin
                fail_cnt++;
                $display("FAIL hdb3_odd[%0d]: sym=%0d rail=%0d ov=%b, expected sym=%0d rail=%0d ov=1", i, s, r, v, es[i], er[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       din [14] = '{1,1,0,0,0,0,0,0,0,0,1,1,1,1};
        int         es  [14] = '{0,0,0,0,1,1,2,0,0,3,2,0,0,3};
        int         er  [14] = '{0,0,0,0,1,-1,1,0,0,1,-1,0,0,-1};
        logic [1:0] s;
        int         r;
        logic       v;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            send4(din[i], 1'b0, s, r, v);
            asrt_cnt++;
            if (s !== 2'(es[i]) || r != er[i] || v !== 1'b1) begin
                fail_cnt++;
                $display("FAIL back_to_back[%0d]: sym=%0d rail=%0d ov=%b, expected sym=%0d rail=%0d ov=1", i, s, r, v, es[i], er[i]);
            end
        end
    endtask

    task automatic test_ami();
        logic       din [11] = '{1,0,0,0,0,0,1,0,0,0,0};
        int         es  [11] = '{0,0,0,0,1,0,0,0,0,0,1};
        int         er  [11] = '{0,0,0,0,1,0,0,0,0,0,-1};
        logic [1:0] s;
        int         r;
        logic       v;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send4(din[i], 1'b1, s, r, v);
            asrt_cnt++;
            if (s !== 2'(es[i]) || r != er[i] || v !== 1'b1) begin
                fail_cnt++;
                $display("FAIL ami[%0d]: sym=%0d rail=%0d ov=%b, expected sym=%0d rail=%0d ov=1", i, s, r, v, es[i], er[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic       din [12] = '{0,0,0,0,0,0,0,0,1,1,1,1};
        logic       md  [12] = '{0,0,1,1,0,0,0,0,0,0,0,0};
        int         es  [12] = '{0,0,0,0,0,0,0,0,2,0,0,3};
        int         er  [12] = '{0,0,0,0,0,0,0,0,1,0,0,1};
        logic [1:0] s;
        int         r;
        logic       v;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send4(din[i], md[i], s, r, v);
            asrt_cnt++;
            if (s !== 2'(es[i]) || r != er[i] || v !== 1'b1) begin
                fail_cnt++;
                $display("FAIL mode_switch[%0d]: sym=%0d rail=%0d ov=%b, expected sym=%0d rail=%0d ov=1", i, s, r, v, es[i], er[i]);
            end
        end
    endtask

    task automatic test_zr3_gaps(input bit gaps);
        logic       din [7] = '{1,0,0,0,1,1,1};
        int         es  [7] = '{0,0,0,1,0,0,3};
        int         er  [7] = '{0,0,0,1,0,0,1};
        int         gap [7] = '{2,0,3,1,0,4,1};
        logic [1:0] s;
        int         r;
        int         rh;
        logic       v;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send3(din[i], s, r, v);
            asrt_cnt++;
            if (s !== 2'(es[i]) || r != er[i] || v !== 1'b1) begin
                fail_cnt++;
                $display("FAIL zr3(gaps=%0d)[%0d]: sym=%0d rail=%0d ov=%b, expected sym=%0d rail=%0d ov=1", gaps, i, s, r, v, es[i], er[i]);
            end
            if (gaps) begin
                for (int g = 0; g < gap[i]; g++) begin
                    @(posedge clk);
                    #1;
                    rh = b3.pos_out ? (b3.neg_out ? 2 : 1) : (b3.neg_out ? -1 : 0);
                    asrt_cnt++;
                    if (b3.sym_out !== 2'(es[i]) || rh != er[i] || b3.out_valid !== 1'b0) begin
                        fail_cnt++;
                        $display("FAIL zr3_hold[%0d.%0d]: sym=%0d rail=%0d ov=%b, expected sym=%0d rail=%0d ov=0", i, g, b3.sym_out, rh, b3.out_valid, es[i], er[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       din [5] = '{1,0,0,0,0};
        logic       dn2 [8] = '{0,0,0,0,1,1,1,1};
        int         es  [8] = '{0,0,0,0,2,0,0,3};
        int         er  [8] = '{0,0,0,0,1,0,0,1};
        logic [1:0] s;
        int         r;
        logic       v;
        do_reset();
        for (int i = 0; i < 5; i++) send4(din[i], 1'b0, s, r, v);
        asrt_cnt++;
        if (s !== 2'd1 || r != 1) begin
            fail_cnt++;
            $display("FAIL reset_mid_pre: sym=%0d rail=%0d, expected sym=1 rail=1", s, r);
        end
        #3;
        rst_n = 1'b0;
        #1;
        asrt_cnt++;
        if ({b4.sym_out, b4.pos_out, b4.neg_out, b4.out_valid} !== 5'b0) begin
            fail_cnt++;
            $display("FAIL reset_mid_async: sym/pos/neg/ov=%b, expected 00000", {b4.sym_out, b4.pos_out, b4.neg_out, b4.out_valid});
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send4(dn2[i], 1'b0, s, r, v);
            asrt_cnt++;
            if (s !== 2'(es[i]) || r != er[i] || v !== 1'b1) begin
                fail_cnt++;
                $display("FAIL reset_mid_after[%0d]: sym=%0d rail=%0d ov=%b, expected sym=%0d rail=%0d ov=1", i, s, r, v, es[i], er[i]);
            end
        end
    endtask

    initial begin
        b4.data_in = 1'b0;
        b4.mode_ami = 1'b0;
        b4.data_valid = 1'b0;
        b3.data_in = 1'b0;
        b3.mode_ami = 1'b0;
        b3.data_valid = 1'b0;
        test_reset();
        test_hdb3_even();
        test_hdb3_odd();
        test_back_to_back();
        test_ami();
        test_mode_switch();
        test_zr3_gaps(1'b0);
        test_zr3_gaps(1'b1);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
        $finish;
    end
endmodule
